lru_replacement_unit: RTL and testbench
=======================================

LRU_REPLACEMENT_UNIT -- requirements
Module: lru_replacement_unit

Interface
REQ-001 SHALL have parameter INDEX_WIDTH, default 6, set index width; NUMBER_OF_SETS = 2**INDEX_WIDTH.
REQ-002 SHALL have parameter SET_ASSOCIATIVITY, default 2, log2 of ways; NUMBER_OF_CACHES = 2**SET_ASSOCIATIVITY; cache numbers are binary, SET_ASSOCIATIVITY bits wide.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clock  input  1  sole clock, rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 accessEnable  input  1  a hit or fill touched a way this cycle.
REQ-007 accessIndex  input  INDEX_WIDTH  set of the touched way.
REQ-008 accessCacheNumber  input  SET_ASSOCIATIVITY  touched way (the tag unit's cacheNumberOut).
REQ-009 victimRequest  input  1  request a replacement way, one-cycle pulse or held.
REQ-010 victimIndex  input  INDEX_WIDTH  set to choose the victim from.
REQ-011 victimValid  output  1  victimCacheNumber is valid this cycle.
REQ-012 victimCacheNumber  output  SET_ASSOCIATIVITY  chosen way (drives the tag unit's cacheNumberIn).

Function
REQ-013 SHALL hold one age field of SET_ASSOCIATIVITY bits per way per set. Within each set the ages SHALL always form a permutation of 0..NUMBER_OF_CACHES-1, where 0 means most recently used.
REQ-014 On a rising edge with accessEnable=1, let A be the age of the accessed way: ways in accessIndex with age < A SHALL increment, the accessed way SHALL become 0, and all other ways SHALL be unchanged.
REQ-015 An access to a way already at age 0 SHALL leave the set unchanged.
REQ-016 Accesses SHALL modify only the addressed set; all other sets SHALL hold their values.
REQ-017 The victim SHALL be the unique way whose age is NUMBER_OF_CACHES-1.
REQ-018 Latency SHALL be one cycle: a request sampled at edge N SHALL give victimValid=1 and victimCacheNumber after edge N, held until edge N+1.
REQ-019 victimValid SHALL be 0 in any cycle that follows an edge where victimRequest=0.
REQ-020 When victimCacheNumber is not valid it SHALL hold its last value.
REQ-021 Holding victimRequest high SHALL give a fresh result every cycle, with no throughput limit.
REQ-022 If accessEnable and victimRequest are both sampled at the same edge and accessIndex=victimIndex, the victim SHALL reflect the post-update ages (forwarding).
REQ-023 If the indices differ in that case, both operations SHALL proceed independently.
REQ-024 A victim request SHALL NOT update ages. The caller performs the fill as a separate access.
REQ-025 accessCacheNumber and accessIndex SHALL be ignored when accessEnable=0; victimIndex SHALL be ignored when victimRequest=0.

Reset
REQ-026 While reset=1, every set SHALL take ages age[w] = NUMBER_OF_CACHES-1-w, so way 0 is the first victim.
REQ-027 While reset=1, victimValid SHALL be 0 and victimCacheNumber SHALL be 0, taking effect immediately without waiting for a clock edge.
REQ-028 Reset asserted mid-operation SHALL discard any pending victim result and all prior ages.
REQ-029 Inputs SHALL be ignored while reset=1.
REQ-030 Normal operation SHALL resume on the first rising edge after reset deasserts.

Verification (defaults: NUMBER_OF_CACHES=4, initial ages [3,2,1,0] for ways 0..3)
REQ-031 Reset, then victimRequest with victimIndex=5 -> next cycle victimValid=1, victimCacheNumber=0.
REQ-032 Access index 3, ways 0, 1, 2 on consecutive cycles, then request index 3 -> victimCacheNumber=3; then access way 3 and request -> 0.
REQ-033 Access index 7, way 2, twice, then request -> ages [3,2,0,1], victimCacheNumber=0; the second access changes nothing.
REQ-034 Same edge: access way 0 at index 9 and request index 9 -> victimCacheNumber=1 (ages [0,3,2,1]). With the request at index 10 instead -> 0.
REQ-035 Access ways 0..3 at index 1, then request index 2 -> victimCacheNumber=0, showing set isolation.
REQ-036 Assert reset between clock edges while victimValid=1 -> victimValid=0 immediately; after release, a request at the previously used index returns 0.
REQ-037 Every test SHALL check the permutation invariant of REQ-013 after every access, using a scoreboard model of the ages.

Source files
------------

// File: rtl/lru_replacement_unit.sv
// True-LRU replacement state for a set-associative cache: per-set age permutation,
// updated on hit/fill and queried for a one-cycle-latency victim way.
module lru_replacement_unit #(
    parameter int unsigned INDEX_WIDTH       = 6,
    parameter int unsigned SET_ASSOCIATIVITY = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         accessEnable,
    input  logic [INDEX_WIDTH-1:0]       accessIndex,
    input  logic [SET_ASSOCIATIVITY-1:0] accessCacheNumber,
    input  logic                         victimRequest,
    input  logic [INDEX_WIDTH-1:0]       victimIndex,
    output logic                         victimValid,
    output logic [SET_ASSOCIATIVITY-1:0] victimCacheNumber
);

    localparam int unsigned NUMBER_OF_SETS   = 2 ** INDEX_WIDTH;
    localparam int unsigned NUMBER_OF_CACHES = 2 ** SET_ASSOCIATIVITY;
    localparam int unsigned SW               = SET_ASSOCIATIVITY;
    localparam int unsigned AW               = NUMBER_OF_CACHES * SW;

    // Way w starts at age NUMBER_OF_CACHES-1-w, so way 0 is the first victim.
    function automatic logic [AW-1:0] reset_ages();
        logic [AW-1:0] r;
        r = '0;
        for (int w = 0; w < int'(NUMBER_OF_CACHES); w++) begin
            r[w*SW +: SW] = SW'(int'(NUMBER_OF_CACHES) - 1 - w);
        end
        return r;
    endfunction

    localparam logic [AW-1:0] RESET_SET = reset_ages();

    logic [AW-1:0] age_q [NUMBER_OF_SETS];

    logic [AW-1:0] access_set;
    logic [AW-1:0] updated_set;
    logic [AW-1:0] victim_set;
    logic [SW-1:0] accessed_age;
    logic [SW-1:0] victim_way;
    logic          forward;

    always_comb begin
        access_set   = age_q[accessIndex];
        accessed_age = '0;
        for (int w = 0; w < int'(NUMBER_OF_CACHES); w++) begin
            if (SW'(w) == accessCacheNumber) begin
                accessed_age = access_set[w*SW +: SW];
            end
        end

        updated_set = access_set;
        for (int w = 0; w < int'(NUMBER_OF_CACHES); w++) begin
            if (SW'(w) == accessCacheNumber) begin
                updated_set[w*SW +: SW] = '0;
            end else if (access_set[w*SW +: SW] < accessed_age) begin
                updated_set[w*SW +: SW] = access_set[w*SW +: SW] + SW'(1);
            end
        end
    end

    // Same-set access and request on one edge: choose from the post-update ages.
    always_comb begin
        forward    = accessEnable && (accessIndex == victimIndex);
        victim_set = forward ? updated_set : age_q[victimIndex];
        victim_way = '0;
        for (int w = 0; w < int'(NUMBER_OF_CACHES); w++) begin
            if (victim_set[w*SW +: SW] == SW'(NUMBER_OF_CACHES - 1)) begin
                victim_way = SW'(w);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < int'(NUMBER_OF_SETS); s++) begin
                age_q[s] <= RESET_SET;
            end
        end else if (accessEnable) begin
            age_q[accessIndex] <= updated_set;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            victimValid       <= 1'b0;
            victimCacheNumber <= '0;
        end else begin
            victimValid <= victimRequest;
            if (victimRequest) begin
                victimCacheNumber <= victim_way;
            end
        end
    end

endmodule

// File: tb/tb_lru_replacement_unit.sv
// Directed bench for lru_replacement_unit: vector table with hand-computed victims,
// an age scoreboard checked after every access, and an asynchronous-reset sequence.
module tb_lru_replacement_unit;

    logic       clock;
    logic       reset;
    logic       accessEnable;
    logic [5:0] accessIndex;
    logic [1:0] accessCacheNumber;
    logic       victimRequest;
    logic [5:0] victimIndex;
    logic       victimValid;
    logic [1:0] victimCacheNumber;

    int n_cmp;
    int n_bad;
    int model [64][4];

    typedef struct {
        logic       ae;
        logic [5:0] ai;
        logic [1:0] ac;
        logic       vr;
        logic [5:0] vi;
        logic       ev;
        logic [1:0] en;
    } vec_t;

    vec_t tbl[$];

    lru_replacement_unit dut (
        .clock             (clock),
        .reset             (reset),
        .accessEnable      (accessEnable),
        .accessIndex       (accessIndex),
        .accessCacheNumber (accessCacheNumber),
        .victimRequest     (victimRequest),
        .victimIndex       (victimIndex),
        .victimValid       (victimValid),
        .victimCacheNumber (victimCacheNumber)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(logic ae, logic [5:0] ai, logic [1:0] ac, logic vr,
                                logic [5:0] vi, logic ev, logic [1:0] en);
        vec_t v;
        v.ae = ae; v.ai = ai; v.ac = ac; v.vr = vr; v.vi = vi; v.ev = ev; v.en = en;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 64; s++)
            for (int w = 0; w < 4; w++)
                model[s][w] = 3 - w;
    endtask

    task automatic model_access(input int s, input int way);
        int a;
        a = model[s][way];
        for (int w = 0; w < 4; w++) begin
            if (w == way) model[s][w] = 0;
            else if (model[s][w] < a) model[s][w] = model[s][w] + 1;
        end
    endtask

    // DUT ages must match the scoreboard and both must be permutations of 0..3.
    task automatic check_set(input logic [5:0] s);
        logic [7:0] packed_ages;
        logic [3:0] seen_dut;
        logic [3:0] seen_mod;
        packed_ages = dut.age_q[s];
        seen_dut = '0;
        seen_mod = '0;
        for (int w = 0; w < 4; w++) begin
            chk($sformatf("age set%0d way%0d", s, w), int'(packed_ages[w*2 +: 2]), model[s][w]);
            seen_dut[packed_ages[w*2 +: 2]] = 1'b1;
            if (model[s][w] >= 0 && model[s][w] < 4) seen_mod[model[s][w]] = 1'b1;
        end
        chk($sformatf("perm dut set%0d", s), int'(seen_dut), 15);
        chk($sformatf("perm model set%0d", s), int'(seen_mod), 15);
    endtask

    task automatic apply(input vec_t v, input int id);
        accessEnable      = v.ae;
        accessIndex       = v.ai;
        accessCacheNumber = v.ac;
        victimRequest     = v.vr;
        victimIndex       = v.vi;
        @(posedge clock);
        if (v.ae) model_access(int'(v.ai), int'(v.ac));
        #1;
        chk($sformatf("vec%0d valid", id), int'(victimValid), int'(v.ev));
        chk($sformatf("vec%0d way", id), int'(victimCacheNumber), int'(v.en));
        if (v.ae) check_set(v.ai);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        accessEnable = 1'b0; accessIndex = '0; accessCacheNumber = '0;
        victimRequest = 1'b0; victimIndex = '0;
        model_reset();
        #1;
        chk("reset valid", int'(victimValid), 0);
        chk("reset way", int'(victimCacheNumber), 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        //           ae  ai ac vr  vi  ev en
        tbl.push_back(mk(0, 0, 0, 1, 5, 1, 0));   // fresh reset: way 0 victim
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));   // no request: valid drops, way held
        tbl.push_back(mk(1, 3, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3, 2, 0, 0, 0, 0));   // set 3 = [2,1,0,3]
        tbl.push_back(mk(0, 0, 0, 1, 3, 1, 3));
        tbl.push_back(mk(1, 3, 3, 0, 0, 0, 3));   // way held while invalid
        tbl.push_back(mk(0, 0, 0, 1, 3, 1, 0));
        tbl.push_back(mk(1, 7, 2, 0, 0, 0, 0));   // set 7 = [3,2,0,1]
        tbl.push_back(mk(1, 7, 2, 0, 0, 0, 0));   // already MRU: unchanged
        tbl.push_back(mk(0, 0, 0, 1, 7, 1, 0));
        tbl.push_back(mk(1, 9, 0, 1, 9, 1, 1));   // forwarded: set 9 = [0,3,2,1]
        tbl.push_back(mk(1, 9, 1, 1, 10, 1, 0));  // independent: set 9 = [1,0,3,2]
        tbl.push_back(mk(0, 0, 0, 1, 9, 1, 2));
        tbl.push_back(mk(0, 3, 2, 0, 3, 0, 2));   // disabled access with live-looking inputs
        tbl.push_back(mk(0, 0, 0, 1, 3, 1, 0));   // set 3 untouched by it
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 2, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 3, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 2, 1, 0));   // set 2 isolated from set 1
        tbl.push_back(mk(0, 0, 0, 1, 3, 1, 0));   // back-to-back requests
        tbl.push_back(mk(0, 0, 0, 1, 9, 1, 2));
        tbl.push_back(mk(1, 9, 3, 1, 9, 1, 3));   // [2,1,3,0] -> hmm way 2? see model
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3));

        // Vector 23: set 9 [1,0,3,2], access way 3 (age 2) -> [2,1,3,0]; oldest is way 2.
        tbl[23].en = 2;
        tbl[24].en = 2;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // Leave a valid result pending, then assert reset between edges.
        apply(mk(0, 0, 0, 1, 9, 1, 2), 100);
        #2 reset = 1'b1;
        #1;
        chk("async reset valid", int'(victimValid), 0);
        chk("async reset way", int'(victimCacheNumber), 0);
        model_reset();
        accessEnable = 1'b1; accessIndex = 6'd9; accessCacheNumber = 2'd2;
        victimRequest = 1'b1; victimIndex = 6'd9;
        @(posedge clock);
        #1;
        chk("reset ignores inputs valid", int'(victimValid), 0);
        chk("reset ignores inputs way", int'(victimCacheNumber), 0);
        check_set(6'd9);
        accessEnable = 1'b0; victimRequest = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;
        apply(mk(0, 0, 0, 1, 9, 1, 0), 101);
        apply(mk(0, 0, 0, 1, 3, 1, 0), 102);
        apply(mk(1, 9, 0, 1, 9, 1, 1), 103);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
